// File: rtl/paint_scheduler.sv
// Paint command scheduler: buffers dot/square/clear commands and rasterises them
// into single-pixel writes on the pixel store's write port when the display allows.
package paint_scheduler_pkg;
  typedef struct packed {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] color;
    logic [1:0] size;
  } paint_cmd_t;

  localparam logic [1:0] OP_DOT    = 2'b00;
  localparam logic [1:0] OP_SQUARE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;
endpackage

module paint_scheduler
  import paint_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XMAX  = 159,
  parameter int unsigned YMAX  = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_x,
  input  logic [7:0] cmd_y,
  input  logic [2:0] cmd_color,
  input  logic [1:0] cmd_size,
  input  logic       wr_allow,
  output logic       we,
  output logic [7:0] wx,
  output logic [7:0] wy,
  output logic [2:0] wcolor,
  output logic       busy,
  output logic       drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;
  localparam logic [7:0] XMAX_8 = 8'(XMAX);
  localparam logic [7:0] YMAX_8 = 8'(YMAX);
  localparam logic [8:0] XMAX_9 = 9'(XMAX);
  localparam logic [8:0] YMAX_9 = 9'(YMAX);

  typedef enum logic {S_IDLE, S_DRAW} state_t;

  paint_cmd_t        r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  state_t            r_state, w_state_nxt;
  logic [7:0]        r_x0, r_x1, r_y1, r_cx, r_cy;
  logic [7:0]        w_x0_nxt, w_x1_nxt, w_y1_nxt, w_cx_nxt, w_cy_nxt;
  logic [2:0]        r_color, w_color_nxt;
  logic              r_we, w_we_nxt;
  logic [7:0]        r_wx, r_wy, w_wx_nxt, w_wy_nxt;
  logic [2:0]        r_wcolor, w_wcolor_nxt;
  logic              r_drop, w_drop_nxt;

  logic              w_empty, w_full, w_push, w_pop, w_oob;
  paint_cmd_t        w_head, w_in;
  logic [8:0]        w_sq_x_sum, w_sq_y_sum;
  logic [7:0]        w_sq_x1, w_sq_y1;

  // FIFO status; full uses the wrap bit so all DEPTH slots are usable
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_push  = cmd_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_in    = '{op: cmd_op, x: cmd_x, y: cmd_y, color: cmd_color, size: cmd_size};

  assign w_oob      = (w_head.x > XMAX_8) || (w_head.y > YMAX_8);
  assign w_sq_x_sum = 9'(w_head.x) + 9'(w_head.size);
  assign w_sq_y_sum = 9'(w_head.y) + 9'(w_head.size);
  assign w_sq_x1    = (w_sq_x_sum > XMAX_9) ? XMAX_8 : w_sq_x_sum[7:0];
  assign w_sq_y1    = (w_sq_y_sum > YMAX_9) ? YMAX_8 : w_sq_y_sum[7:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_in;
    end
  end

  // Next-state, raster walk and write-port outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_x0_nxt     = r_x0;
    w_x1_nxt     = r_x1;
    w_y1_nxt     = r_y1;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_color_nxt  = r_color;
    w_we_nxt     = 1'b0;
    w_wx_nxt     = r_wx;
    w_wy_nxt     = r_wy;
    w_wcolor_nxt = r_wcolor;
    w_drop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          case (w_head.op)
            OP_DOT, OP_SQUARE: begin
              if (w_oob) begin
                w_drop_nxt = 1'b1;
              end else begin
                w_x0_nxt    = w_head.x;
                w_cx_nxt    = w_head.x;
                w_cy_nxt    = w_head.y;
                w_x1_nxt    = (w_head.op == OP_SQUARE) ? w_sq_x1 : w_head.x;
                w_y1_nxt    = (w_head.op == OP_SQUARE) ? w_sq_y1 : w_head.y;
                w_color_nxt = w_head.color;
                w_state_nxt = S_DRAW;
              end
            end
            OP_CLEAR: begin
              w_x0_nxt    = 8'd0;
              w_cx_nxt    = 8'd0;
              w_cy_nxt    = 8'd0;
              w_x1_nxt    = XMAX_8;
              w_y1_nxt    = YMAX_8;
              w_color_nxt = w_head.color;
              w_state_nxt = S_DRAW;
            end
            default: begin
            end
          endcase
        end
      end
      S_DRAW: begin
        if (wr_allow) begin
          w_we_nxt     = 1'b1;
          w_wx_nxt     = r_cx;
          w_wy_nxt     = r_cy;
          w_wcolor_nxt = r_color;
          if (r_cx < r_x1) begin
            w_cx_nxt = r_cx + 8'd1;
          end else if (r_cy < r_y1) begin
            w_cx_nxt = r_x0;
            w_cy_nxt = r_cy + 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_x0     <= 8'd0;
      r_x1     <= 8'd0;
      r_y1     <= 8'd0;
      r_cx     <= 8'd0;
      r_cy     <= 8'd0;
      r_color  <= 3'd0;
      r_we     <= 1'b0;
      r_wx     <= 8'd0;
      r_wy     <= 8'd0;
      r_wcolor <= 3'd0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_x0     <= w_x0_nxt;
      r_x1     <= w_x1_nxt;
      r_y1     <= w_y1_nxt;
      r_cx     <= w_cx_nxt;
      r_cy     <= w_cy_nxt;
      r_color  <= w_color_nxt;
      r_we     <= w_we_nxt;
      r_wx     <= w_wx_nxt;
      r_wy     <= w_wy_nxt;
      r_wcolor <= w_wcolor_nxt;
      r_drop   <= w_drop_nxt;
    end
  end

  assign cmd_ready = !w_full;
  assign busy      = (r_state == S_DRAW) || !w_empty;
  assign we        = r_we;
  assign wx        = r_wx;
  assign wy        = r_wy;
  assign wcolor    = r_wcolor;
  assign drop      = r_drop;

endmodule

// File: tb/tb_paint_scheduler.sv
// Directed bench for paint_scheduler: logs every write strobe and checks it
// against hand-derived pixel sequences, latencies and flow-control behaviour.
module tb_paint_scheduler;
  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_x;
  logic [7:0] cmd_y;
  logic [2:0] cmd_color;
  logic [1:0] cmd_size;
  logic       wr_allow;
  logic       we;
  logic [7:0] wx;
  logic [7:0] wy;
  logic [2:0] wcolor;
  logic       busy;
  logic       drop;

  paint_scheduler dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .cmd_size(cmd_size), .wr_allow(wr_allow), .we(we), .wx(wx), .wy(wy),
    .wcolor(wcolor), .busy(busy), .drop(drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Write log captured just after each rising edge
  int cyc = 0;
  int q_x[$];
  int q_y[$];
  int q_c[$];
  int q_cyc[$];
  int drop_cnt = 0;
  int bad_allow = 0;
  logic tog_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (we === 1'b1) begin
      q_x.push_back(int'(wx));
      q_y.push_back(int'(wy));
      q_c.push_back(int'(wcolor));
      q_cyc.push_back(cyc);
      if (wr_allow !== 1'b1) bad_allow++;
    end
    if (drop === 1'b1) drop_cnt++;
  end

  always @(negedge clk) begin
    if (tog_en) wr_allow = ~wr_allow;
  end

  task automatic clear_log();
    q_x.delete();
    q_y.delete();
    q_c.delete();
    q_cyc.delete();
  endtask

  task automatic push_cmd(input logic [1:0] op, input int x, input int y,
                          input int c, input int s, output int acc);
    int n;
    @(negedge clk);
    cmd_op    = op;
    cmd_x     = 8'(x);
    cmd_y     = 8'(y);
    cmd_color = 3'(c);
    cmd_size  = 2'(s);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", int'(cmd_ready), 1);
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int acc;
    int d0;
    int bad;
    int n;
    int ex[4];
    int ey[4];

    reset = 1'b0; cmd_valid = 1'b0; wr_allow = 1'b0;
    cmd_op = 2'd0; cmd_x = 8'd0; cmd_y = 8'd0; cmd_color = 3'd0; cmd_size = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(we), 0);
    check("rst_wx", int'(wx), 0);
    check("rst_wy", int'(wy), 0);
    check("rst_wcolor", int'(wcolor), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;

    // Single dot: one write, visible two edges after acceptance
    wr_allow = 1'b1;
    clear_log();
    push_cmd(2'b00, 10, 20, 5, 0, acc);
    wait_idle();
    check("dot_count", q_x.size(), 1);
    if (q_x.size() == 1) begin
      check("dot_x", q_x[0], 10);
      check("dot_y", q_y[0], 20);
      check("dot_color", q_c[0], 5);
      check("dot_latency", q_cyc[0] - acc, 2);
    end
    check("dot_busy_after", int'(busy), 0);

    // Square size 2 at (5,7): 3x3 raster, back-to-back writes
    clear_log();
    push_cmd(2'b01, 5, 7, 3, 2, acc);
    wait_idle();
    check("sq_count", q_x.size(), 9);
    if (q_x.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("sq_x[%0d]", i), q_x[i], 5 + i % 3);
        check($sformatf("sq_y[%0d]", i), q_y[i], 7 + i / 3);
        check($sformatf("sq_c[%0d]", i), q_c[i], 3);
        check($sformatf("sq_cyc[%0d]", i), q_cyc[i] - q_cyc[0], i);
      end
    end

    // Square clipped at bottom-right corner
    clear_log();
    ex = '{158, 159, 158, 159};
    ey = '{118, 118, 119, 119};
    push_cmd(2'b01, 158, 118, 1, 3, acc);
    wait_idle();
    check("clip_count", q_x.size(), 4);
    if (q_x.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("clip_x[%0d]", i), q_x[i], ex[i]);
        check($sformatf("clip_y[%0d]", i), q_y[i], ey[i]);
      end
    end

    // Out-of-range dot: dropped, no write
    clear_log();
    d0 = drop_cnt;
    push_cmd(2'b00, 160, 0, 2, 0, acc);
    wait_idle();
    check("oob_writes", q_x.size(), 0);
    check("oob_drops", drop_cnt - d0, 1);

    // Backpressure: first dot stalls in DRAW, next four fill the FIFO
    @(negedge clk);
    wr_allow = 1'b0;
    clear_log();
    for (int i = 0; i < 5; i++) push_cmd(2'b00, 30 + i, 40, i, 0, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ready_low", int'(cmd_ready), 0);
    end
    check("bp_busy", int'(busy), 1);
    check("bp_no_writes", q_x.size(), 0);
    @(negedge clk);
    wr_allow = 1'b1;
    push_cmd(2'b00, 35, 40, 5, 0, acc);
    wait_idle();
    check("bp_count", q_x.size(), 6);
    if (q_x.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("bp_x[%0d]", i), q_x[i], 30 + i);
        check($sformatf("bp_c[%0d]", i), q_c[i], i);
      end
    end

    // Full clear with wr_allow toggling every cycle
    clear_log();
    bad_allow = 0;
    @(negedge clk);
    tog_en = 1'b1;
    push_cmd(2'b10, 0, 0, 6, 0, acc);
    wait_idle();
    tog_en = 1'b0;
    @(negedge clk);
    wr_allow = 1'b1;
    check("clr_count", q_x.size(), 19200);
    check("clr_allow_violations", bad_allow, 0);
    bad = 0;
    n = q_x.size();
    for (int i = 0; i < n; i++) begin
      if (q_x[i] != i % 160 || q_y[i] != i / 160 || q_c[i] != 6) bad++;
    end
    check("clr_order_errors", bad, 0);
    if (n > 0) begin
      check("clr_last_x", q_x[n-1], 159);
      check("clr_last_y", q_y[n-1], 119);
    end

    // Reset in the middle of a clear with two commands queued behind it
    clear_log();
    push_cmd(2'b10, 0, 0, 4, 0, acc);
    push_cmd(2'b00, 1, 1, 1, 0, acc);
    push_cmd(2'b00, 2, 2, 2, 0, acc);
    n = 0;
    @(negedge clk);
    while (q_x.size() < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("mid_rst_we", int'(we), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_writes", q_x.size(), 100);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_writes", q_x.size(), 100);
    check("post_rst_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
